// File: rtl/snake_body_map.sv
// -----------------------------------------------------------------------------
// snake_body_map
//
// Owns the GRID_W x GRID_H snake occupancy bitmap and the circular FIFO of body
// segment coordinates. Serves one-cycle-latency pixel reads to the VGA stage
// and applies one move per accepted step request, reporting fatal moves.
//
// Ports:
//   clk_25M     pixel clock, shared with the VGA stage
//   rst_n       asynchronous active-low reset (reruns CLEAR + SEED)
//   pixel_x/y   VGA read coordinate
//   pixel_data  occupancy of the cell addressed on the previous cycle
//   step_valid  move request; accepted when step_ready is high
//   step_ready  high only while idle and able to take a move
//   new_head_x/y, grow  move payload, sampled on the accepting edge only
//   head_x/y    current head cell
//   length      current segment count
//   collide     one-cycle pulse on a fatal move, after which the block is dead
//
// Build option:
//   SNAKE_WRAP_EN  when defined, requested coordinates wrap around the grid
//                  edges instead of a wall hit being fatal.
// -----------------------------------------------------------------------------
module snake_body_map #(
  parameter int unsigned GRID_W   = 40,
  parameter int unsigned GRID_H   = 30,
  parameter int unsigned MAX_LEN  = 64,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned INIT_X   = 10,
  parameter int unsigned INIT_Y   = 15
) (
  input  logic       clk_25M,
  input  logic       rst_n,
  input  logic [5:0] pixel_x,
  input  logic [5:0] pixel_y,
  output logic       pixel_data,
  input  logic       step_valid,
  output logic       step_ready,
  input  logic [5:0] new_head_x,
  input  logic [5:0] new_head_y,
  input  logic       grow,
  output logic [5:0] head_x,
  output logic [5:0] head_y,
  output logic [6:0] length,
  output logic       collide
);

  localparam int unsigned CELLS = GRID_W * GRID_H;
  localparam int unsigned AW    = $clog2(CELLS);
  localparam int unsigned PW    = $clog2(MAX_LEN);

  localparam logic [5:0]    GW        = 6'(GRID_W);
  localparam logic [5:0]    GH        = 6'(GRID_H);
  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
  localparam logic [AW-1:0] LAST_SEED = AW'(INIT_LEN - 1);
  localparam logic [6:0]    FULL_LEN  = 7'(MAX_LEN);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_SEED,
    S_IDLE,
    S_RD,
    S_CMP,
    S_POP,
    S_WR,
    S_DEAD
  } state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic [5:0]    nh_x, nh_y;
  logic          grow_l;
  logic          rd_bit;
  logic [PW-1:0] wptr, rptr;

  logic          bitmap [CELLS];
  logic [5:0]    fifo_x [MAX_LEN];
  logic [5:0]    fifo_y [MAX_LEN];

  // Port B / FIFO write controls
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic          b_wdata;
  logic          f_we;
  logic [5:0]    f_x, f_y;

  logic [5:0]    tail_x, tail_y, seed_x;
  logic          nh_ok, a_ok;
  logic [AW-1:0] a_addr;

  function automatic logic [AW-1:0] addr_of(input logic [5:0] x, input logic [5:0] y);
    return AW'(y) * AW'(GRID_W) + AW'(x);
  endfunction

`ifdef SNAKE_WRAP_EN
  function automatic logic [5:0] wrap_x(input logic [5:0] x);
    if (x == 6'd63)  return GW - 6'd1;
    else if (x >= GW) return x - GW;
    else              return x;
  endfunction

  function automatic logic [5:0] wrap_y(input logic [5:0] y);
    if (y == 6'd63)  return GH - 6'd1;
    else if (y >= GH) return y - GH;
    else              return y;
  endfunction
`else
  function automatic logic [5:0] wrap_x(input logic [5:0] x);
    return x;
  endfunction

  function automatic logic [5:0] wrap_y(input logic [5:0] y);
    return y;
  endfunction
`endif

  assign tail_x = fifo_x[rptr];
  assign tail_y = fifo_y[rptr];
  assign seed_x = 6'(INIT_X) + cnt[5:0];
  assign nh_ok  = (nh_x < GW) && (nh_y < GH);
  assign a_addr = addr_of(pixel_x, pixel_y);
  assign a_ok   = (pixel_x < GW) && (pixel_y < GH) &&
                  (state != S_CLEAR) && (state != S_SEED);

  always_comb begin
    b_we    = 1'b0;
    b_addr  = addr_of(nh_x, nh_y);
    b_wdata = 1'b0;
    f_we    = 1'b0;
    f_x     = nh_x;
    f_y     = nh_y;
    case (state)
      S_CLEAR: begin
        b_we   = 1'b1;
        b_addr = cnt;
      end
      S_SEED: begin
        b_we    = 1'b1;
        b_addr  = addr_of(seed_x, 6'(INIT_Y));
        b_wdata = 1'b1;
        f_we    = 1'b1;
        f_x     = seed_x;
        f_y     = 6'(INIT_Y);
      end
      S_POP: begin
        b_we   = 1'b1;
        b_addr = addr_of(tail_x, tail_y);
      end
      S_WR: begin
        b_we    = 1'b1;
        b_wdata = 1'b1;
        f_we    = 1'b1;
      end
      default: ;
    endcase
  end

  // Storage: bitmap port B, FIFO push. Non-blocking writes give the VGA port
  // the old value on a same-cycle read/write collision.
  always_ff @(posedge clk_25M) begin
    if (b_we)
      bitmap[b_addr] <= b_wdata;
    if (state == S_RD && nh_ok)
      rd_bit <= bitmap[b_addr];
    if (f_we) begin
      fifo_x[wptr] <= f_x;
      fifo_y[wptr] <= f_y;
    end
  end

  // Port A: VGA read, blanked off-grid and while the map is being rebuilt
  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n)
      pixel_data <= 1'b0;
    else if (a_ok)
      pixel_data <= bitmap[a_addr];
    else
      pixel_data <= 1'b0;
  end

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CLEAR;
      cnt        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      nh_x       <= '0;
      nh_y       <= '0;
      grow_l     <= 1'b0;
      head_x     <= 6'(INIT_X + INIT_LEN - 1);
      head_y     <= 6'(INIT_Y);
      length     <= 7'(INIT_LEN);
      step_ready <= 1'b0;
      collide    <= 1'b0;
    end else begin
      collide <= 1'b0;
      case (state)
        S_CLEAR: begin
          if (cnt == LAST_CELL) begin
            cnt   <= '0;
            state <= S_SEED;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        S_SEED: begin
          wptr <= wptr + PW'(1);
          if (cnt == LAST_SEED) begin
            cnt        <= '0;
            step_ready <= 1'b1;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        S_IDLE: begin
          if (step_valid && step_ready) begin
            nh_x       <= wrap_x(new_head_x);
            nh_y       <= wrap_y(new_head_y);
            // A full snake cannot grow; the move degrades to a plain step.
            grow_l     <= grow && (length != FULL_LEN);
            step_ready <= 1'b0;
            state      <= S_RD;
          end
        end
        S_RD: begin
          if (!nh_ok) begin
            collide <= 1'b1;
            state   <= S_DEAD;
          end else begin
            state <= S_CMP;
          end
        end
        S_CMP: begin
          // The tail cell is vacated this step unless growing, so it is legal.
          if (rd_bit && !(nh_x == tail_x && nh_y == tail_y && !grow_l)) begin
            collide <= 1'b1;
            state   <= S_DEAD;
          end else if (grow_l) begin
            state <= S_WR;
          end else begin
            state <= S_POP;
          end
        end
        S_POP: begin
          rptr  <= rptr + PW'(1);
          state <= S_WR;
        end
        S_WR: begin
          wptr       <= wptr + PW'(1);
          head_x     <= nh_x;
          head_y     <= nh_y;
          if (grow_l)
            length <= length + 7'd1;
          step_ready <= 1'b1;
          state      <= S_IDLE;
        end
        S_DEAD: ;
        default: state <= S_DEAD;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_map.sv
// -----------------------------------------------------------------------------
// tb_snake_body_map
//
// Scoreboard bench for snake_body_map. The driver pushes expected events
// (reset snapshot, step completion, collision, pixel read) into queues; the
// monitor pops and compares whenever the DUT presents the matching response.
// -----------------------------------------------------------------------------
module tb_snake_body_map;

  logic       clk_25M = 1'b0;
  logic       rst_n   = 1'b0;
  logic [5:0] pixel_x = '0;
  logic [5:0] pixel_y = '0;
  logic       pixel_data;
  logic       step_valid = 1'b0;
  logic       step_ready;
  logic [5:0] new_head_x = '0;
  logic [5:0] new_head_y = '0;
  logic       grow = 1'b0;
  logic [5:0] head_x, head_y;
  logic [6:0] length;
  logic       collide;

  snake_body_map dut (
    .clk_25M    (clk_25M),
    .rst_n      (rst_n),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .pixel_data (pixel_data),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .new_head_x (new_head_x),
    .new_head_y (new_head_y),
    .grow       (grow),
    .head_x     (head_x),
    .head_y     (head_y),
    .length     (length),
    .collide    (collide)
  );

  always #20 clk_25M = ~clk_25M;

  typedef enum int {K_RST, K_RDY, K_COL} kind_e;

  typedef struct {
    kind_e      kind;
    string      name;
    int         busy;
    logic [5:0] hx;
    logic [5:0] hy;
    logic [6:0] len;
  } ev_t;

  typedef struct {
    string name;
    logic  exp;
  } pix_t;

  ev_t  ev_q[$];
  pix_t pix_q[$];

  int vectors    = 0;
  int miscompares = 0;

  logic rd_strobe = 1'b0;
  logic rd_valid  = 1'b0;
  always @(posedge clk_25M) rd_valid <= rd_strobe;

  task automatic end_sim();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // ---------------------------------------------------------------- monitor
  int   low_cnt  = 0;
  logic prev_rdy = 1'b0;
  bit   dead_chk = 1'b0;

  always @(negedge clk_25M) begin
    ev_t  e;
    pix_t p;
    if (rd_valid) begin
      vectors++;
      if (pix_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_read: pixel_data=%0b with no read pending", pixel_data);
      end else begin
        p = pix_q.pop_front();
        if (pixel_data !== p.exp) begin
          miscompares++;
          $display("FAIL %s: pixel_data=%0b want %0b", p.name, pixel_data, p.exp);
        end
      end
    end

    if (!rst_n) begin
      low_cnt  = 0;
      dead_chk = 1'b0;
      if (ev_q.size() != 0 && ev_q[0].kind == K_RST) begin
        e = ev_q.pop_front();
        vectors++;
        if (step_ready !== 1'b0 || collide !== 1'b0 || pixel_data !== 1'b0 ||
            head_x !== e.hx || head_y !== e.hy || length !== e.len) begin
          miscompares++;
          $display("FAIL %s: rdy=%0b col=%0b pix=%0b head=(%0d,%0d) len=%0d want 0/0/0 (%0d,%0d) len=%0d",
                   e.name, step_ready, collide, pixel_data, head_x, head_y, length, e.hx, e.hy, e.len);
        end
      end
    end else if (collide === 1'b1) begin
      vectors++;
      if (ev_q.size() != 0 && ev_q[0].kind == K_COL) begin
        e = ev_q.pop_front();
        dead_chk = 1'b1;
        if (head_x !== e.hx || head_y !== e.hy || length !== e.len) begin
          miscompares++;
          $display("FAIL %s: head=(%0d,%0d) len=%0d want (%0d,%0d) len=%0d",
                   e.name, head_x, head_y, length, e.hx, e.hy, e.len);
        end
      end else begin
        miscompares++;
        $display("FAIL unexpected_collide: collide=1 head=(%0d,%0d) len=%0d", head_x, head_y, length);
      end
    end else if (dead_chk) begin
      dead_chk = 1'b0;
      vectors++;
      if (step_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL dead_after_collide: step_ready=%0b want 0", step_ready);
      end
    end

    if (rst_n && prev_rdy === 1'b0 && step_ready === 1'b1) begin
      vectors++;
      if (ev_q.size() != 0 && ev_q[0].kind == K_RDY) begin
        e = ev_q.pop_front();
        if (low_cnt != e.busy || head_x !== e.hx || head_y !== e.hy || length !== e.len) begin
          miscompares++;
          $display("FAIL %s: busy=%0d head=(%0d,%0d) len=%0d want busy=%0d head=(%0d,%0d) len=%0d",
                   e.name, low_cnt, head_x, head_y, length, e.busy, e.hx, e.hy, e.len);
        end
      end else begin
        miscompares++;
        $display("FAIL unexpected_ready: step_ready rose after %0d low cycles, none expected", low_cnt);
      end
    end

    if (rst_n) begin
      if (step_ready === 1'b1) low_cnt = 0;
      else                     low_cnt++;
    end
    prev_rdy = step_ready;
  end

  // ----------------------------------------------------------------- driver
  task automatic push_ev(input kind_e k, input string nm, input int busy,
                         input logic [5:0] hx, input logic [5:0] hy, input logic [6:0] len);
    ev_t e;
    e.kind = k; e.name = nm; e.busy = busy; e.hx = hx; e.hy = hy; e.len = len;
    ev_q.push_back(e);
  endtask

  task automatic wait_ready(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (step_ready === 1'b1) return;
      @(posedge clk_25M); #1;
    end
    vectors++;
    miscompares++;
    $display("FAIL ready_timeout: step_ready=%0b after %0d cycles, want 1", step_ready, bound);
    end_sim();
  endtask

  task automatic do_reset(input string nm);
    push_ev(K_RST, {nm, "_rst"}, 0, 6'd12, 6'd15, 7'd3);
    rst_n = 1'b0;
    repeat (3) @(posedge clk_25M);
    #1 rst_n = 1'b1;
    push_ev(K_RDY, {nm, "_boot"}, 1203, 6'd12, 6'd15, 7'd3);
    wait_ready(1300);
  endtask

  task automatic rd(input logic [5:0] x, input logic [5:0] y, input logic e);
    pix_t p;
    p.name = $sformatf("pix(%0d,%0d)", x, y);
    p.exp  = e;
    pix_q.push_back(p);
    pixel_x   = x;
    pixel_y   = y;
    rd_strobe = 1'b1;
    @(posedge clk_25M); #1;
    rd_strobe = 1'b0;
  endtask

  task automatic do_step(input logic [5:0] x, input logic [5:0] y, input logic g,
                         input int busy, input logic [5:0] ex, input logic [5:0] ey,
                         input logic [6:0] el, input bit col, input string nm);
    wait_ready(50);
    push_ev(col ? K_COL : K_RDY, nm, busy, ex, ey, el);
    new_head_x = x;
    new_head_y = y;
    grow       = g;
    step_valid = 1'b1;
    @(posedge clk_25M); #1;
    step_valid = 1'b0;
    grow       = 1'b0;
    if (col) begin
      repeat (8) @(posedge clk_25M);
      #1;
    end else begin
      wait_ready(50);
    end
  endtask

  initial begin
    #(40 * 60000);
    vectors++;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached, pending events=%0d", ev_q.size());
    end_sim();
  end

  initial begin
    // Boot: CLEAR + SEED, then seeded body visible
    do_reset("boot");
    rd(6'd10, 6'd15, 1'b1);
    rd(6'd11, 6'd15, 1'b1);
    rd(6'd12, 6'd15, 1'b1);
    rd(6'd13, 6'd15, 1'b0);
    rd(6'd45, 6'd2,  1'b0);
    rd(6'd0,  6'd0,  1'b0);

    // Plain step: tail vacates, head advances
    do_step(6'd13, 6'd15, 1'b0, 4, 6'd13, 6'd15, 7'd3, 1'b0, "step13");
    rd(6'd10, 6'd15, 1'b0);
    rd(6'd13, 6'd15, 1'b1);
    rd(6'd11, 6'd15, 1'b1);

    // 2x2 loop: into own tail is legal without grow, fatal with grow
    do_step(6'd13, 6'd14, 1'b1, 3, 6'd13, 6'd14, 7'd4, 1'b0, "grow_13_14");
    do_step(6'd12, 6'd14, 1'b0, 4, 6'd12, 6'd14, 7'd4, 1'b0, "step_12_14");
    do_step(6'd12, 6'd15, 1'b0, 4, 6'd12, 6'd15, 7'd4, 1'b0, "into_tail");
    rd(6'd12, 6'd15, 1'b1);
    rd(6'd11, 6'd15, 1'b0);
    do_step(6'd13, 6'd15, 1'b1, 0, 6'd12, 6'd15, 7'd4, 1'b1, "tail_grow_col");
    // Dead: requests ignored, map frozen but still readable
    new_head_x = 6'd20; new_head_y = 6'd20; step_valid = 1'b1;
    repeat (3) @(posedge clk_25M);
    #1 step_valid = 1'b0;
    rd(6'd12, 6'd15, 1'b1);
    rd(6'd13, 6'd15, 1'b1);
    rd(6'd13, 6'd14, 1'b1);
    repeat (10) @(posedge clk_25M);
    #1;

    // Wall / wrap
    do_reset("wall");
    rd(6'd12, 6'd14, 1'b0);
    rd(6'd13, 6'd14, 1'b0);
`ifdef SNAKE_WRAP_EN
    do_step(6'd40, 6'd15, 1'b0, 4, 6'd0, 6'd15, 7'd3, 1'b0, "wrap_x40");
    rd(6'd0,  6'd15, 1'b1);
    rd(6'd10, 6'd15, 1'b0);
    do_step(6'd63, 6'd15, 1'b0, 4, 6'd39, 6'd15, 7'd3, 1'b0, "wrap_x63");
`else
    do_step(6'd40, 6'd15, 1'b0, 0, 6'd12, 6'd15, 7'd3, 1'b1, "wall_x40");
    repeat (6) @(posedge clk_25M);
    #1;
`endif

    // Grow to saturation: row 15 rightwards, then row 16 leftwards
    do_reset("fill");
    for (int k = 1; k <= 61; k++) begin
      logic [5:0] x, y;
      if (k <= 27) begin x = 6'(12 + k); y = 6'd15; end
      else         begin x = 6'(39 - (k - 28)); y = 6'd16; end
      do_step(x, y, 1'b1, 3, x, y, 7'(3 + k), 1'b0, $sformatf("grow%0d", k));
    end
    do_step(6'd5, 6'd16, 1'b1, 4, 6'd5, 6'd16, 7'd64, 1'b0, "grow_full");
    rd(6'd10, 6'd15, 1'b0);
    rd(6'd11, 6'd15, 1'b1);
    rd(6'd5,  6'd16, 1'b1);
    do_step(6'd4, 6'd16, 1'b0, 4, 6'd4, 6'd16, 7'd64, 1'b0, "step_full");
    rd(6'd11, 6'd15, 1'b0);
    rd(6'd12, 6'd15, 1'b1);
    rd(6'd39, 6'd15, 1'b1);
    rd(6'd39, 6'd16, 1'b1);
    rd(6'd3,  6'd16, 1'b0);

    // Reset while the step is in POP: step lost, map rebuilt
    wait_ready(50);
    new_head_x = 6'd3; new_head_y = 6'd16; grow = 1'b0; step_valid = 1'b1;
    @(posedge clk_25M); #1;
    step_valid = 1'b0;
    @(posedge clk_25M);
    @(posedge clk_25M); #1;
    do_reset("midpop");
    rd(6'd4,  6'd16, 1'b0);
    rd(6'd3,  6'd16, 1'b0);
    rd(6'd39, 6'd16, 1'b0);
    rd(6'd20, 6'd15, 1'b0);
    rd(6'd13, 6'd15, 1'b0);
    rd(6'd10, 6'd15, 1'b1);
    rd(6'd11, 6'd15, 1'b1);
    rd(6'd12, 6'd15, 1'b1);
    do_step(6'd13, 6'd15, 1'b0, 4, 6'd13, 6'd15, 7'd3, 1'b0, "after_reset");

    repeat (5) @(posedge clk_25M);
    #1;
    while (ev_q.size() != 0) begin
      ev_t e;
      e = ev_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: event never observed, want kind=%0d", e.name, e.kind);
    end
    while (pix_q.size() != 0) begin
      pix_t p;
      p = pix_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: read never observed, want %0b", p.name, p.exp);
    end
    end_sim();
  end

endmodule
